// File: rtl/ntt_bf_addsub.sv
// Kyber NTT butterfly add/subtract stage (q = 3329): aligns a with the multiplier
// product t, normalises both, then produces (a+t) mod q and (a-t) mod q.
module ntt_bf_addsub #(
  parameter int Q        = 3329,
  parameter int MULT_LAT = 3,
  parameter int PAIRS    = 128,
  localparam int CW      = $clog2(PAIRS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [11:0]   a_in,
  input  logic [11:0]   t_in,
  output logic [11:0]   x_out,
  output logic [11:0]   y_out,
  output logic          out_valid,
  output logic [CW-1:0] bf_count,
  output logic          layer_done
);

  localparam logic [11:0] Q12 = 12'(Q);
  localparam logic [12:0] Q13 = 13'(Q);

  // Delay line carrying {valid, a} until the matching product arrives on t_in.
  logic [MULT_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [11:0]         dl_a_q [MULT_LAT];
  logic [11:0]         dl_a_d [MULT_LAT];

  always_comb begin
    dl_valid_d[0] = in_valid;
    dl_a_d[0]     = a_in;
    for (int i = 1; i < MULT_LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_a_d[i]     = dl_a_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_valid_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) dl_a_q[i] <= '0;
    end else begin
      dl_valid_q <= dl_valid_d;
      for (int i = 0; i < MULT_LAT; i++) dl_a_q[i] <= dl_a_d[i];
    end
  end

  // Normalise stage: a single conditional subtract brings 0..4095 into 0..q-1.
  logic        n_valid_q, n_valid_d;
  logic [11:0] n_a_q, n_a_d;
  logic [11:0] n_t_q, n_t_d;

  always_comb begin
    n_valid_d = dl_valid_q[MULT_LAT-1];
    n_a_d     = (dl_a_q[MULT_LAT-1] >= Q12) ? dl_a_q[MULT_LAT-1] - Q12 : dl_a_q[MULT_LAT-1];
    n_t_d     = (t_in >= Q12) ? t_in - Q12 : t_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_valid_q <= 1'b0;
      n_a_q     <= '0;
      n_t_q     <= '0;
    end else begin
      n_valid_q <= n_valid_d;
      n_a_q     <= n_a_d;
      n_t_q     <= n_t_d;
    end
  end

  // Add/subtract stage; outputs hold their last value across bubbles.
  logic [12:0] sum;
  logic [12:0] diff;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    sum         = {1'b0, n_a_q} + {1'b0, n_t_q};
    diff        = (n_a_q >= n_t_q) ? ({1'b0, n_a_q} - {1'b0, n_t_q})
                                   : ({1'b0, n_a_q} + Q13 - {1'b0, n_t_q});
    out_valid_d = n_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    if (n_valid_q) begin
      x_d = (sum >= Q13) ? 12'(sum - Q13) : sum[11:0];
      y_d = diff[11:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Layer counter: terminal count is decoded combinationally from the register.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          layer_done_c;

  always_comb begin
    layer_done_c = out_valid_q && (cnt_q == CW'(PAIRS - 1));
    cnt_d        = cnt_q;
    if (out_valid_q) begin
      cnt_d = layer_done_c ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign out_valid  = out_valid_q;
  assign bf_count   = cnt_q;
  assign layer_done = layer_done_c;

endmodule
